// File: rtl/jump_controller.sv
// jump_controller
//   Debounces a raw jump key, derives a once-per-frame physics strobe from the
//   scan position, and runs a three-state (IDLE/RISE/FALL) jump trajectory.
//   Height h counts pixels above the ground; char_y is the sprite top row.
//
// Ports
//   clock        in   pixel clock
//   reset        in   asynchronous active-low reset
//   jump_key     in   raw asynchronous key, active-high
//   display_row  in   [10:0] current scan row
//   display_col  in   [11:0] current scan column
//   char_y       out  [10:0] registered character top row (GROUND_Y - h)
//   airborne     out  registered, high while the state is not IDLE
//   frame_tick   out  registered one-cycle physics update strobe
//
// Build option
//   DOUBLE_JUMP_EN : when defined, one extra request per jump is accepted
//                    while airborne and relaunches at the next tick.
module jump_controller #(
    parameter int DEBOUNCE_CYCLES = 1080000,
    parameter int VBLANK_ROW      = 1024,
    parameter int GROUND_Y        = 800,
    parameter int JUMP_V0         = 20,
    parameter int GRAVITY         = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        jump_key,
    input  logic [10:0] display_row,
    input  logic [11:0] display_col,
    output logic [10:0] char_y,
    output logic        airborne,
    output logic        frame_tick
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0]       VB_ROW   = 11'(VBLANK_ROW);
    localparam logic [10:0]       GROUND_H = 11'(GROUND_Y);
    localparam logic signed [11:0] GROUND_N = 12'(GROUND_Y);
    localparam logic [10:0]       H_LAUNCH = 11'(JUMP_V0);
    localparam logic signed [8:0] V_LAUNCH = 9'(JUMP_V0 - GRAVITY);
    localparam logic signed [8:0] V_GRAV   = 9'(GRAVITY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_e;

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    db_level_q, db_level_d;
    logic [CNT_W-1:0]        db_cnt_q, db_cnt_d;
    logic                    pending_q, pending_d;
    logic                    frame_tick_q, frame_tick_d;
    state_e                  state_q, state_d;
    logic [10:0]             h_q, h_d;
    logic signed [8:0]       v_q, v_d;
    logic [10:0]             char_y_q, char_y_d;
    logic                    airborne_q, airborne_d;
    logic                    key_rise_s;
    logic                    accept_s;
    logic signed [11:0]      n_s;
    logic signed [8:0]       v_next_s;
`ifdef DOUBLE_JUMP_EN
    logic                    dj_used_q, dj_used_d;
    logic [11:0]             dj_sum_s;
`endif

    // Key synchronizer and debounce counter; a bounce back to the current level restarts the count.
    always_comb begin
        sync1_d    = jump_key;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == CNT_LAST) begin
                db_level_d = ~db_level_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d   = db_cnt_q + CNT_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
        // Rise is flagged in the cycle the level flips so a coincident tick can consume it.
        key_rise_s   = db_level_d & ~db_level_q;
        frame_tick_d = (display_row == VB_ROW) && (display_col == 12'd0);
    end

    // Jump state machine: next state, height/velocity update and request bookkeeping.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        pending_d = pending_q;
        n_s       = $signed({1'b0, h_q}) + $signed({{3{v_q[8]}}, v_q});
        v_next_s  = v_q - V_GRAV;
`ifdef DOUBLE_JUMP_EN
        dj_used_d = dj_used_q;
        dj_sum_s  = {1'b0, h_q} + 12'(JUMP_V0);
        accept_s  = (state_q == IDLE) || !dj_used_q;
`else
        accept_s  = (state_q == IDLE);
`endif
        if (key_rise_s && accept_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (frame_tick_q) begin
            case (state_q)
                IDLE: begin
                    if (pending_q || key_rise_s) begin
                        h_d       = H_LAUNCH;
                        v_d       = V_LAUNCH;
                        pending_d = 1'b0;
                        state_d   = RISE;
                    end else begin
                        state_d   = IDLE;
                    end
                end
                RISE, FALL: begin
`ifdef DOUBLE_JUMP_EN
                    if (pending_q && !dj_used_q) begin
                        dj_used_d = 1'b1;
                        pending_d = 1'b0;
                        if (dj_sum_s > 12'(GROUND_Y)) begin
                            h_d     = GROUND_H;
                            v_d     = 9'sd0;
                            state_d = FALL;
                        end else begin
                            h_d     = dj_sum_s[10:0];
                            v_d     = V_LAUNCH;
                            state_d = RISE;
                        end
                    end else
`endif
                    if (n_s <= 12'sd0) begin
                        // Landing: a pending request waits for the next tick.
                        h_d     = 11'd0;
                        v_d     = 9'sd0;
                        state_d = IDLE;
`ifdef DOUBLE_JUMP_EN
                        dj_used_d = 1'b0;
`endif
                    end else if (n_s > GROUND_N) begin
                        h_d     = GROUND_H;
                        v_d     = 9'sd0;
                        state_d = FALL;
                    end else begin
                        h_d     = n_s[10:0];
                        v_d     = v_next_s;
                        state_d = (v_next_s > 9'sd0) ? RISE : FALL;
                    end
                end
                default: begin
                    h_d     = 11'd0;
                    v_d     = 9'sd0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        char_y_d   = GROUND_H - h_d;
        airborne_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            state_q      <= IDLE;
            h_q          <= 11'd0;
            v_q          <= 9'sd0;
            char_y_q     <= GROUND_H;
            airborne_q   <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            dj_used_q    <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            char_y_q     <= char_y_d;
            airborne_q   <= airborne_d;
`ifdef DOUBLE_JUMP_EN
            dj_used_q    <= dj_used_d;
`endif
        end
    end

    assign char_y     = char_y_q;
    assign airborne   = airborne_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_jump_controller.sv
`timescale 1ns/1ps
module tb_jump_controller;
    localparam int DEB   = 4;
    localparam int VB    = 12;
    localparam int GY    = 800;
    localparam int V0    = 20;
    localparam int G     = 2;
    localparam int ROWS  = 16;
    localparam int COLS  = 4;
    localparam int FRAME = ROWS * COLS;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        jump_key = 1'b0;
    logic [10:0] display_row = 11'd0;
    logic [11:0] display_col = 12'd0;
    logic [10:0] char_y;
    logic        airborne;
    logic        frame_tick;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int cy;
        bit air;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: heights/velocities as plain integers.
    int  m_h, m_v, m_n;
    bit  m_air, m_pend, m_dj_used, m_level, m_match;
    bit  m_d1, m_d2;
    bit  m_win[$];
    bit  m_sync, m_rise, m_tick, m_accept, m_consumed, m_dj;

    // Monitor state
    bit   mon_seen_tick;
    int   mon_exp_cy;
    bit   mon_exp_air;
    exp_t mon_e;

    jump_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .VBLANK_ROW(VB),
        .GROUND_Y(GY),
        .JUMP_V0(V0),
        .GRAVITY(G)
    ) dut (
        .clock(clock),
        .reset(reset),
        .jump_key(jump_key),
        .display_row(display_row),
        .display_col(display_col),
        .char_y(char_y),
        .airborne(airborne),
        .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit window_all_differ(input bit level);
        foreach (m_win[i]) begin
            if (m_win[i] == level) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_air = 0; m_pend = 0; m_dj_used = 0;
        m_level = 0; m_match = 0; m_d1 = 0; m_d2 = 0;
        m_win.delete();
        exp_q.delete();
    endtask

    // Behavioural model: key delay line + "last DEB samples all differ" debounce,
    // tick derived from scan position, trajectory from the jump rules.
    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                m_sync = m_d2;
                m_d2   = m_d1;
                m_d1   = jump_key;
                m_win.push_back(m_sync);
                if (m_win.size() > DEB) void'(m_win.pop_front());
                m_rise = 1'b0;
                if (m_win.size() == DEB && window_all_differ(m_level)) begin
                    m_level = !m_level;
                    m_rise  = m_level;
                end

                m_tick  = m_match;
                m_match = (display_row == 11'(VB)) && (display_col == 12'd0);

                m_accept = !m_air;
`ifdef DOUBLE_JUMP_EN
                if (m_air && !m_dj_used) m_accept = 1'b1;
`endif
                m_consumed = 1'b0;
                if (m_tick) begin
                    if (!m_air) begin
                        if (m_pend || m_rise) begin
                            m_h = V0; m_v = V0 - G; m_air = 1'b1; m_consumed = 1'b1;
                        end
                    end else begin
                        m_dj = 1'b0;
`ifdef DOUBLE_JUMP_EN
                        if (m_pend && !m_dj_used) begin
                            m_dj = 1'b1; m_consumed = 1'b1; m_dj_used = 1'b1;
                            if (m_h + V0 > GY) begin m_h = GY; m_v = 0; end
                            else begin m_h = m_h + V0; m_v = V0 - G; end
                        end
`endif
                        if (!m_dj) begin
                            m_n = m_h + m_v;
                            if (m_n <= 0) begin
                                m_h = 0; m_v = 0; m_air = 1'b0; m_dj_used = 1'b0;
                            end else if (m_n > GY) begin
                                m_h = GY; m_v = 0;
                            end else begin
                                m_h = m_n; m_v = m_v - G;
                            end
                        end
                    end
                    exp_q.push_back('{cy: GY - m_h, air: m_air});
                end
                if (m_consumed) m_pend = 1'b0;
                else if (m_rise && m_accept) m_pend = 1'b1;
            end
        end
    end

    // Monitor: pops one expectation per DUT frame_tick and checks outputs every cycle.
    initial begin
        mon_seen_tick = 1'b0;
        mon_exp_cy    = GY;
        mon_exp_air   = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_seen_tick = 1'b0;
                mon_exp_cy    = GY;
                mon_exp_air   = 1'b0;
                check("reset_char_y", char_y, GY);
                check("reset_airborne", airborne, 0);
                check("reset_frame_tick", frame_tick, 0);
            end else begin
                if (mon_seen_tick) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_tick: got a DUT tick, expected none at %0t", $time);
                    end else begin
                        mon_e       = exp_q.pop_front();
                        mon_exp_cy  = mon_e.cy;
                        mon_exp_air = mon_e.air;
                    end
                end
                check("char_y", char_y, mon_exp_cy);
                check("airborne", airborne, mon_exp_air);
                check("frame_tick", frame_tick, m_match);
                mon_seen_tick = frame_tick;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (display_col == 12'(COLS - 1)) begin
            display_col = 12'd0;
            display_row = (display_row == 11'(ROWS - 1)) ? 11'd0 : display_row + 11'd1;
        end else begin
            display_col = display_col + 12'd1;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int len);
        jump_key = 1'b1;
        steps(len);
        jump_key = 1'b0;
    endtask

    initial begin
        // Reset held low for 3 cycles.
        #2 reset = 1'b0;
        steps(3);
        reset = 1'b1;
        steps(10);

        // Bounce 1,0,1 at 2-cycle spacing then held: one request.
        jump_key = 1'b1; steps(2);
        jump_key = 1'b0; steps(2);
        jump_key = 1'b1; steps(4);
        jump_key = 1'b0; steps(12);
        steps(25 * FRAME);
        // 3-cycle glitch while idle: no request.
        press(3);
        steps(3 * FRAME);

        // Plain jump over a full trajectory.
        press(8);
        steps(24 * FRAME);

        // Second request mid-jump.
        press(8);
        steps(5 * FRAME);
        press(8);
        steps(30 * FRAME);

        // Reset mid-jump aborts immediately, then relaunch.
        press(8);
        steps(8 * FRAME + 10);
        reset = 1'b0;
        #1;
        check("async_reset_char_y", char_y, GY);
        check("async_reset_airborne", airborne, 0);
        steps(3);
        reset = 1'b1;
        steps(5);
        press(8);
        steps(25 * FRAME);

        // Request edge coincident with frame_tick: align key to the scan.
        for (int i = 0; i < FRAME + 2; i++) begin
            if (display_row == 11'(VB - 1) && display_col == 12'd0) break;
            step();
        end
        check("align_row", display_row, VB - 1);
        jump_key = 1'b1;
        steps(6);
        check("coincident_launch_char_y", char_y, GY - V0);
        check("coincident_launch_airborne", airborne, 1);
        jump_key = 1'b0;
        steps(25 * FRAME);

        // Randomized key activity, bounces and presses at arbitrary phases.
        for (int j = 0; j < 12; j++) begin
            int nev;
            nev = $urandom_range(3, 8);
            for (int k = 0; k < nev; k++) begin
                steps($urandom_range(1, 40));
                press($urandom_range(1, 8));
            end
            steps(FRAME * $urandom_range(2, 10));
        end
        steps(40 * FRAME);
        steps(2);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jump_controller.md
JUMP_CONTROLLER -- requirements
Module: jump_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1080000, is the number of stable cycles required before the debounced key level changes (10 ms at 108 MHz).
REQ-002 Parameter VBLANK_ROW, default 1024, is the display_row value that marks the start of vertical blanking.
REQ-003 Parameter GROUND_Y, default 800, is the character top row when on the ground.
REQ-004 Parameter JUMP_V0, default 20, is the launch velocity in pixels per frame.
REQ-005 Parameter GRAVITY, default 2, is the velocity decrement per frame.
REQ-006 Port clock: input, 1 bit, pixel clock.
REQ-007 Port reset: input, 1 bit, asynchronous active-low reset.
REQ-008 Port jump_key: input, 1 bit, raw asynchronous key, active-high.
REQ-009 Port display_row: input, 11 bits, current scan row.
REQ-010 Port display_col: input, 12 bits, current scan column.
REQ-011 Port char_y: output, 11 bits, registered character top row, consumed by the character sprite stage.
REQ-012 Port airborne: output, 1 bit, registered; high while state is not IDLE.
REQ-013 Port frame_tick: output, 1 bit, registered one-cycle physics update strobe.

Function
REQ-014 jump_key SHALL pass a 2-flop synchronizer, then a counter that updates the debounced level only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized value; any bounce SHALL restart the count.
REQ-015 A 0->1 edge of the debounced level SHALL set a request-pending flag.
REQ-016 frame_tick SHALL pulse for exactly one cycle when display_row==VBLANK_ROW and display_col==0, once per frame.
REQ-017 The state machine SHALL have three states: IDLE, RISE and FALL, and SHALL change state only on a frame_tick.
REQ-018 On a tick in IDLE with a request pending: h=JUMP_V0, v=JUMP_V0-GRAVITY, clear pending, go to RISE.
REQ-019 On a tick in RISE or FALL with n=h+v (signed, 12-bit): if n<=0 then h=0, v=0, go to IDLE; else h=n, v=v-GRAVITY, next state RISE if the new v>0, else FALL.
REQ-020 If n>GROUND_Y: clamp h=GROUND_Y, v=0, go to FALL.
REQ-021 h SHALL be an 11-bit unsigned value and v a 9-bit signed value.
REQ-022 char_y SHALL equal GROUND_Y-h, registered, and update one cycle after frame_tick.
REQ-023 A request edge in the same cycle as frame_tick SHALL be honoured on that tick.
REQ-024 Request edges arriving while airborne SHALL be discarded (the pending flag is not set), unless DOUBLE_JUMP_EN is defined.
REQ-025 The landing tick and a pending request SHALL NOT launch in the same tick; the relaunch occurs at the next tick.

Reset
REQ-026 While reset is low: state=IDLE, h=0, v=0, char_y=GROUND_Y, airborne=0, frame_tick=0, pending=0, debounced level=0, counter=0, synchronizer flops=0; reset asserted mid-jump SHALL abort the jump immediately.

Configuration
REQ-027 Macro DOUBLE_JUMP_EN: when defined, one request edge while airborne SHALL be accepted per jump. At the next tick it SHALL set v=JUMP_V0-GRAVITY, set h=h+JUMP_V0 (clamped per REQ-020) and go to RISE. Landing SHALL re-arm this allowance. When undefined, REQ-024 applies.

Verification
(Bench parameters: DEBOUNCE_CYCLES=4, JUMP_V0=20, GRAVITY=2, GROUND_Y=800, small scan counters.)
REQ-028 Reset held low for 3 cycles -> char_y=800, airborne=0, no frame_tick.
REQ-029 Key bounces 1,0,1 with 2-cycle spacing, then held for 4 cycles -> exactly one request; a 3-cycle glitch -> no request.
REQ-030 Request then 21 ticks:
- tick 1 gives char_y=780;
- ticks 10 and 11 give char_y=690 (peak), with state FALL from tick 10;
- tick 21 gives char_y=800, airborne=0.
REQ-031 Request at tick 5 of a jump, DOUBLE_JUMP_EN undefined -> trajectory identical to REQ-030; defined -> tick 6 gives h=80+20+... and state RISE (h=80+20=100 pre-update path per REQ-027).
REQ-032 Reset asserted at tick 8 of a jump -> char_y=800 and airborne=0 asynchronously; after release, the next request relaunches with char_y=780.
REQ-033 Request edge coincident with frame_tick -> launch on that tick, char_y=780 one cycle later.
